// File: rtl/stream_row_capture.sv
// AXI4-Stream pixel receiver: thresholds each pixel to a cell and writes complete rows to a BRAM port.
// Optional statistics counters are built when STREAM_CAPTURE_STATS_EN is defined.
module stream_row_capture #(
  parameter int          X_SIZE       = 1280,
  parameter int          Y_SIZE       = 720,
  parameter logic [7:0]  ALIVE_THRESH = 8'h00,
  localparam int         AW           = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1,
  localparam int         XW           = (X_SIZE > 1) ? $clog2(X_SIZE) : 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [31:0]       s_stream_tdata,
  input  logic [3:0]        s_stream_tkeep,
  input  logic              s_stream_tlast,
  input  logic              s_stream_tuser,
  input  logic              s_stream_tvalid,
  output logic              s_stream_tready,
  output logic              row_wr_en,
  output logic [AW-1:0]     row_wr_addr,
  output logic [X_SIZE-1:0] row_wr_data,
  output logic              frame_done,
  output logic              sync_err,
  output logic [15:0]       frame_count,
  output logic [15:0]       err_count
);

  typedef enum logic [1:0] {WAIT_SOF = 2'd0, CAPTURE = 2'd1, WRITE = 2'd2} state_t;

  localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
  localparam logic [AW-1:0] Y_LAST = AW'(Y_SIZE - 1);

  state_t              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [AW-1:0]       y_q, y_d;
  logic [X_SIZE-1:0]   row_q, row_d;
  logic [X_SIZE-1:0]   row_shift_s;
  logic                tready_q, tready_d;
  logic                wr_en_q, wr_en_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [X_SIZE-1:0]   wr_data_q, wr_data_d;
  logic                frame_done_q, frame_done_d;
  logic                sync_err_q, sync_err_d;
  logic                accept_s;
  logic                cell_s;
  logic                unused_bits;

  assign unused_bits = ^{s_stream_tkeep, s_stream_tdata[31:24], s_stream_tdata[15:0]};

  // Next-state, row assembly and output computation
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    row_d        = row_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    accept_s     = s_stream_tvalid && tready_q;
    cell_s       = (s_stream_tdata[23:16] > ALIVE_THRESH);
    row_shift_s  = {row_q[X_SIZE-2:0], cell_s};
    case (state_q)
      WAIT_SOF: begin
        if (accept_s && s_stream_tuser) begin
          row_d   = row_shift_s;
          x_d     = XW'(1);
          y_d     = '0;
          state_d = CAPTURE;
        end else begin
          state_d = WAIT_SOF;
        end
      end
      CAPTURE: begin
        if (accept_s) begin
          row_d = row_shift_s;
          // A new start of frame always wins over any other framing check
          if (s_stream_tuser) begin
            sync_err_d = 1'b1;
            x_d        = XW'(1);
            y_d        = '0;
          end else if (x_q == X_LAST) begin
            if (s_stream_tlast) begin
              state_d   = WRITE;
              wr_en_d   = 1'b1;
              wr_addr_d = y_q;
              wr_data_d = row_shift_s;
            end else begin
              sync_err_d = 1'b1;
              state_d    = WAIT_SOF;
            end
          end else if (s_stream_tlast) begin
            sync_err_d = 1'b1;
            state_d    = WAIT_SOF;
          end else begin
            x_d = x_q + XW'(1);
          end
        end else begin
          state_d = CAPTURE;
        end
      end
      WRITE: begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          frame_done_d = 1'b1;
          y_d          = '0;
          state_d      = WAIT_SOF;
        end else begin
          y_d     = y_q + AW'(1);
          state_d = CAPTURE;
        end
      end
      default: begin
        state_d = WAIT_SOF;
        x_d     = '0;
        y_d     = '0;
      end
    endcase
    tready_d = (state_d != WRITE);
  end

  // State and registered-output flops
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= WAIT_SOF;
      x_q          <= '0;
      y_q          <= '0;
      row_q        <= '0;
      tready_q     <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      row_q        <= row_d;
      tready_q     <= tready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign s_stream_tready = tready_q;
  assign row_wr_en       = wr_en_q;
  assign row_wr_addr     = wr_addr_q;
  assign row_wr_data     = wr_data_q;
  assign frame_done      = frame_done_q;
  assign sync_err        = sync_err_q;

`ifdef STREAM_CAPTURE_STATS_EN
  logic [15:0] frame_count_q, frame_count_d;
  logic [15:0] err_count_q, err_count_d;

  // Saturating event counters, updated alongside their pulses
  always_comb begin
    frame_count_d = frame_count_q;
    err_count_d   = err_count_q;
    if (frame_done_d && (frame_count_q != 16'hFFFF)) begin
      frame_count_d = frame_count_q + 16'd1;
    end else begin
      frame_count_d = frame_count_q;
    end
    if (sync_err_d && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // Counter flops
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frame_count_q <= 16'h0000;
      err_count_q   <= 16'h0000;
    end else begin
      frame_count_q <= frame_count_d;
      err_count_q   <= err_count_d;
    end
  end

  assign frame_count = frame_count_q;
  assign err_count   = err_count_q;
`else
  assign frame_count = 16'h0000;
  assign err_count   = 16'h0000;
`endif

endmodule

// File: doc/stream_row_capture.md
Name: stream_row_capture

Overview:
- AXI4-Stream receiver, the opposite end of the pixel generator's video stream.
- Accepts one 24-bit RGB pixel per 32-bit beat and thresholds each pixel to a 1-bit cell state.
- Assembles X_SIZE cells into one row and writes each complete row to a BRAM write port, row-addressed.
- Used for loopback checking of the video path and for capturing an externally rendered grid back into cell memory.

Parameters:
X_SIZE, 1280, pixels per line / bits per row word
Y_SIZE, 720, lines per frame
ALIVE_THRESH, 8'h00, cell alive when R channel > ALIVE_THRESH

Ports:
aclk  in  1  sole clock
aresetn  in  1  asynchronous active-low reset
s_stream_tdata  in  32  pixel; [23:16]=R, [15:8]=G, [7:0]=B, [31:24] ignored
s_stream_tkeep  in  4  ignored
s_stream_tlast  in  1  end of line
s_stream_tuser  in  1  start of frame
s_stream_tvalid  in  1  beat valid
s_stream_tready  out  1  beat accepted when tvalid&tready
row_wr_en  out  1  one-cycle row write strobe
row_wr_addr  out  $clog2(Y_SIZE)  row index 0..Y_SIZE-1
row_wr_data  out  X_SIZE  row cells; pixel x sits at bit X_SIZE-1-x
frame_done  out  1  one-cycle pulse after row Y_SIZE-1 is written
sync_err  out  1  one-cycle pulse on framing violation
frame_count  out  16  frames completed (feature only)
err_count  out  16  sync errors (feature only)

Behaviour:
- Reset (async assert, sync release): state=WAIT_SOF, x=0, y=0, row register=0. All outputs 0, including tready while aresetn is low.
- Accepted beat: cell = (tdata[23:16] > ALIVE_THRESH). Row register shifts left by one and the cell enters bit 0, so pixel 0 ends at the MSB.
- WAIT_SOF: tready=1.
  - Beats without tuser are discarded silently.
  - A beat with tuser is captured as pixel (0,0): x=1, y=0, go to CAPTURE.
- CAPTURE: tready=1. Each accepted beat shifts in a cell and increments x.
  - Beat at x==X_SIZE-1 with tlast=1: go to WRITE.
  - Beat at x==X_SIZE-1 with tlast=0: sync_err pulse, row dropped, go to WAIT_SOF.
  - tlast on a beat with x<X_SIZE-1: sync_err pulse, row dropped, go to WAIT_SOF.
  - tuser on any beat: sync_err pulse, restart as WAIT_SOF would. The beat becomes pixel (0,0), y=0, and rows already written are not rolled back.
  - tuser together with an early tlast: the tuser rule wins.
- WRITE (exactly 1 cycle): tready=0, row_wr_en=1, row_wr_addr=y, row_wr_data=row register.
  - Write occurs the cycle after the last beat of the line is accepted.
  - Next cycle, if y==Y_SIZE-1: frame_done=1, y=0, go to WAIT_SOF.
  - Otherwise: y=y+1, x=0, go to CAPTURE.
- row_wr_addr and row_wr_data hold their last values when row_wr_en=0.
- Throughput: X_SIZE+1 cycles per line minimum; tvalid gaps are tolerated with no timeout.
- Mid-operation reset drops any partial row and writes nothing.
- frame_done and sync_err never assert in the same cycle.

Optional Feature:
STREAM_CAPTURE_STATS_EN
- Defined: frame_count increments on each frame_done and err_count on each sync_err. Both saturate at 16'hFFFF and reset to 0.
- Undefined: both ports are tied to 0 and no counter logic is built.

Test Plan:
- Full frame: 1280x720 beats, tuser on first, tlast on every 1280th, pixel x alive when x%2==0 → 720 writes, addr 0..719, data 1280'hAAAA…AA each, one frame_done on the cycle after the write to addr 719.
- Threshold: R=8'h00 then R=8'hCB, G/B arbitrary, ALIVE_THRESH=0 → row MSB=0, next bit=1. R=8'h01 → alive.
- Early tlast at x=100 of row 3 → sync_err pulse, no write at addr 3. Subsequent beats without tuser are ignored until the next tuser.
- tuser at x=500 of row 10 → sync_err pulse, that beat becomes pixel (0,0), the next completed row writes to addr 0.
- Backpressure/gaps: tvalid toggled randomly → tready=0 only in WRITE cycles, captured data identical to the gap-free run.
- Async reset mid-row 5, then full frame → all outputs 0 during reset, first write to addr 0. With STREAM_CAPTURE_STATS_EN: frame_count=1, err_count=0.
